// File: rtl/note_sequencer.sv
// Step sequencer feeding the four channel frequency buses from a writable pattern memory.
// Optional SEQ_GATE_EN: mutes the outputs during the last GATE_TICKS cycles of every step.
module note_sequencer #(
    parameter int STEPS          = 16,
    parameter int ADDR_W         = 4,
    parameter int TICKS_PER_STEP = 1000,
    parameter int GATE_TICKS     = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] last_step,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_chan,
    input  logic [7:0]        wr_data,
    output logic [7:0]        freq1,
    output logic [7:0]        freq2,
    output logic [7:0]        freq3,
    output logic [7:0]        freq4,
    output logic [ADDR_W-1:0] step_idx,
    output logic              step_tick,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    if (TICKS_PER_STEP < 2 || GATE_TICKS >= TICKS_PER_STEP || STEPS != (1 << ADDR_W)) begin : g_bad_params
        $error("note_sequencer: inconsistent parameters");
    end

    // One 8-bit word per (step, channel); address is {step, channel}.
    logic [7:0] mem [0:STEPS*4-1];

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] step_reg, step_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [ADDR_W-1:0] last_reg, last_next;
    logic              load;
    logic              audible;
    logic              step_tick_reg, done_reg, busy_reg;
    logic              done_next;
    logic [31:0]       freq_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS*4; i++) mem[i] <= 8'd0;
        end else if (wr_en) begin
            mem[{wr_addr, wr_chan}] <= wr_data;
        end
    end

    // Priority: stop > start > pause > tick advance.
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        tick_next  = tick_reg;
        last_next  = last_reg;
        load       = 1'b0;
        done_next  = 1'b0;
        if (stop && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            step_next  = '0;
            tick_next  = '0;
        end else if (start && !stop) begin
            state_next = S_PLAY;
            step_next  = '0;
            tick_next  = '0;
            last_next  = last_step;
            load       = 1'b1;
        end else if (state_reg == S_PLAY) begin
            if (pause) begin
                // A step-end cycle stays parked at TICK_LAST so the advance fires after resume.
                state_next = S_PAUSE;
                if (tick_reg != TICK_LAST) tick_next = tick_reg + 1'b1;
            end else if (tick_reg != TICK_LAST) begin
                tick_next = tick_reg + 1'b1;
            end else if (step_reg < last_reg) begin
                step_next = step_reg + 1'b1;
                tick_next = '0;
                load      = 1'b1;
            end else if (loop_en) begin
                step_next = '0;
                tick_next = '0;
                load      = 1'b1;
            end else begin
                state_next = S_IDLE;
                step_next  = '0;
                tick_next  = '0;
                done_next  = 1'b1;
            end
        end else if (state_reg == S_PAUSE && !pause) begin
            state_next = S_PLAY;
        end
    end

`ifdef SEQ_GATE_EN
    assign audible = (state_next == S_PLAY) && (int'(tick_next) < TICKS_PER_STEP - GATE_TICKS);
`else
    assign audible = (state_next == S_PLAY);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            step_reg      <= '0;
            tick_reg      <= '0;
            last_reg      <= '0;
            step_tick_reg <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            step_reg      <= step_next;
            tick_reg      <= tick_next;
            last_reg      <= last_next;
            step_tick_reg <= load;
            done_reg      <= done_next;
            busy_reg      <= (state_next != S_IDLE);
        end
    end

    // Per channel: held word survives pause/gate; the output register is muted as needed.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        localparam logic [1:0] CH = 2'(gi);
        logic [7:0] held_reg, held_next, freq_reg;

        assign held_next = load ? mem[{step_next, CH}] : held_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                held_reg <= 8'd0;
                freq_reg <= 8'd0;
            end else begin
                held_reg <= held_next;
                freq_reg <= audible ? held_next : 8'd0;
            end
        end

        assign freq_all[gi*8 +: 8] = freq_reg;
    end

    assign freq1     = freq_all[7:0];
    assign freq2     = freq_all[15:8];
    assign freq3     = freq_all[23:16];
    assign freq4     = freq_all[31:24];
    assign step_idx  = step_reg;
    assign step_tick = step_tick_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios plus randomized traffic against a step/position model.
// Honours SEQ_GATE_EN the same way the design does.
module tb_note_sequencer;

    localparam int STEPS = 16;
    localparam int AW    = 4;
    localparam int TPS   = 4;
    localparam int GATE  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [AW-1:0] last_step = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [1:0]    wr_chan = '0;
    logic [7:0]    wr_data = '0;
    logic [7:0]    freq1, freq2, freq3, freq4;
    logic [AW-1:0] step_idx;
    logic          step_tick, busy, done;

    note_sequencer #(
        .STEPS(STEPS), .ADDR_W(AW), .TICKS_PER_STEP(TPS), .GATE_TICKS(GATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .last_step(last_step), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_chan(wr_chan), .wr_data(wr_data), .freq1(freq1), .freq2(freq2),
        .freq3(freq3), .freq4(freq4), .step_idx(step_idx), .step_tick(step_tick),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: playing/held flags, step number and position within the step.
    bit m_play, m_held;
    int m_step, m_pos, m_last;
    int m_pat [STEPS][4];
    int m_snd [4];
    bit m_tick, m_done;

    function automatic int exp_freq(int c);
        if (!m_play || m_held) return 0;
`ifdef SEQ_GATE_EN
        if (m_pos >= TPS - GATE) return 0;
`endif
        return m_snd[c];
    endfunction

    task automatic model_reset();
        m_play = 0; m_held = 0; m_step = 0; m_pos = 0; m_last = 0;
        m_tick = 0; m_done = 0;
        for (int s = 0; s < STEPS; s++)
            for (int c = 0; c < 4; c++) m_pat[s][c] = 0;
        for (int c = 0; c < 4; c++) m_snd[c] = 0;
    endtask

    task automatic model_load(int s);
        m_step = s; m_pos = 0; m_tick = 1;
        for (int c = 0; c < 4; c++) m_snd[c] = m_pat[s][c];
    endtask

    task automatic model_step();
        m_tick = 0; m_done = 0;
        if (stop && m_play) begin
            m_play = 0; m_held = 0; m_step = 0; m_pos = 0;
        end else if (start && !stop) begin
            m_play = 1; m_held = 0; m_last = int'(last_step);
            model_load(0);
        end else if (m_play && !m_held) begin
            if (pause) begin
                m_held = 1;
                if (m_pos < TPS - 1) m_pos++;
            end else if (m_pos < TPS - 1) m_pos++;
            else if (m_step < m_last) model_load(m_step + 1);
            else if (loop_en) model_load(0);
            else begin
                m_play = 0; m_step = 0; m_pos = 0; m_done = 1;
            end
        end else if (m_play && m_held && !pause) begin
            m_held = 0;
        end
        // A load reads the pattern before this cycle's write lands.
        if (wr_en) m_pat[wr_addr][wr_chan] = int'(wr_data);
    endtask

    task automatic check_all();
        chk("freq1", freq1, exp_freq(0));
        chk("freq2", freq2, exp_freq(1));
        chk("freq3", freq3, exp_freq(2));
        chk("freq4", freq4, exp_freq(3));
        chk("step_idx", step_idx, m_step);
        chk("step_tick", step_tick, m_tick);
        chk("busy", busy, m_play);
        chk("done", done, m_done);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_freq1"}, freq1, 0);
        chk({tag, "_freq4"}, freq4, 0);
        chk({tag, "_step"}, step_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tick"}, step_tick, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // One clock: model consumes the current inputs, DUT is sampled 1 ns after the edge.
    task automatic tick();
        model_step();
        @(posedge clk); #1;
        check_all();
        start = 0; stop = 0; wr_en = 0;
    endtask

    task automatic write_word(input int s, input int c, input int d);
        wr_en = 1; wr_addr = AW'(s); wr_chan = 2'(c); wr_data = 8'(d);
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int c = 0; c < 4; c++) begin
            write_word(0, c, 10 + 10*c);
            write_word(1, c, 11 + 10*c);
        end

        // Two-step single pass ending in done.
        last_step = 1; loop_en = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 1) start = 1;
            tick();
            chk("one_tick", step_tick, int'(k == 1 || k == 5));
            chk("one_done", done, int'(k == 9));
`ifndef SEQ_GATE_EN
            chk("one_freq1", freq1, (k <= 4) ? 10 : (k <= 8) ? 11 : 0);
`endif
        end

        // Looping: steps alternate, no done; stop in step1, then start+stop together.
        loop_en = 1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) start = 1;
            if (k == 14) stop = 1;
            tick();
            if (k <= 13) begin
                chk("loop_step", step_idx, ((k - 1) / 4) % 2);
                chk("loop_done", done, 0);
            end else begin
                check_zero("stop");
            end
        end
        start = 1; stop = 1;
        tick();
        check_zero("start_stop");

        // Pause during cycles 2..4 delays the step1 load by three cycles.
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) start = 1;
            pause = (k >= 3 && k <= 5);
            if (k == 10) stop = 1;
            tick();
            if (k <= 9) chk("pause_tick", step_tick, int'(k == 1 || k == 8));
            if (k >= 3 && k <= 5) chk("pause_freq1", freq1, 0);
        end

        // Write landing on the cycle step1 loads: old word now, new word next pass.
        for (int k = 1; k <= 14; k++) begin
            if (k == 1) start = 1;
            if (k == 5) begin
                wr_en = 1; wr_addr = 1; wr_chan = 0; wr_data = 99;
            end
            if (k == 14) stop = 1;
            tick();
`ifndef SEQ_GATE_EN
            if (k == 5) chk("wol_old", freq1, 11);
            if (k == 13) chk("wol_new", freq1, 99);
`endif
        end

        // Randomized traffic with one asynchronous reset mid-run.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 8) pause = ~pause;
            loop_en = ($urandom_range(0, 99) < 70);
            last_step = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, STEPS - 1))
                                                    : AW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 20) begin
                wr_en = 1;
                wr_addr = AW'($urandom_range(0, STEPS - 1));
                wr_chan = 2'($urandom_range(0, 3));
                wr_data = 8'($urandom_range(0, 255));
            end
            if (i == 800) begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_rst");
                model_reset();
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 0; stop = 0; wr_en = 0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
